// File: rtl/decode_inst_queue_if.sv
// decode_inst_queue_if
//   Bundles the decode-side push lanes, the rename-side pop handshake and the
//   queue status outputs of decode_inst_queue.
//   Macro INSTQ_PERF_COUNT_EN adds fullStallCnt_o (32-bit stall counter).
//
//   master : decode/rename side (drives packets, valids, renReady_i, flush_i)
//   slave  : the queue itself (drives stall, output packets, valids, count)
//
//   Signals
//     flush_i                      discard queued and incoming packets
//     decPacket0_i/decPacket1_i    decode lane packets (PKT_W)
//     decValid0_i/decValid1_i      lane packet valid
//     stallDecode_o                decode must hold its packets
//     renReady_i                   rename consumes all valid outputs this cycle
//     renPacket0_o/renPacket1_o    oldest / second-oldest entry (PKT_W)
//     renValid0_o/renValid1_o      output packet valid
//     count_o                      occupancy, log2(DEPTH)+1 bits
interface decode_inst_queue_if #(
  parameter int PKT_W = 128,
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush_i;
  logic [PKT_W-1:0] decPacket0_i;
  logic [PKT_W-1:0] decPacket1_i;
  logic             decValid0_i;
  logic             decValid1_i;
  logic             stallDecode_o;
  logic             renReady_i;
  logic [PKT_W-1:0] renPacket0_o;
  logic [PKT_W-1:0] renPacket1_o;
  logic             renValid0_o;
  logic             renValid1_o;
  logic [CNT_W-1:0] count_o;
`ifdef INSTQ_PERF_COUNT_EN
  logic [31:0]      fullStallCnt_o;

  modport master (
    output flush_i, decPacket0_i, decPacket1_i, decValid0_i, decValid1_i, renReady_i,
    input  stallDecode_o, renPacket0_o, renPacket1_o, renValid0_o, renValid1_o, count_o,
           fullStallCnt_o
  );
  modport slave (
    input  flush_i, decPacket0_i, decPacket1_i, decValid0_i, decValid1_i, renReady_i,
    output stallDecode_o, renPacket0_o, renPacket1_o, renValid0_o, renValid1_o, count_o,
           fullStallCnt_o
  );
`else
  modport master (
    output flush_i, decPacket0_i, decPacket1_i, decValid0_i, decValid1_i, renReady_i,
    input  stallDecode_o, renPacket0_o, renPacket1_o, renValid0_o, renValid1_o, count_o
  );
  modport slave (
    input  flush_i, decPacket0_i, decPacket1_i, decValid0_i, decValid1_i, renReady_i,
    output stallDecode_o, renPacket0_o, renPacket1_o, renValid0_o, renValid1_o, count_o
  );
`endif
endinterface

// File: rtl/decode_inst_queue.sv
// decode_inst_queue
//   Two-wide circular instruction queue between decode and rename. Up to two
//   packets are pushed per cycle (compacted, lane 0 first) and up to two are
//   popped per cycle when rename is ready. Flush empties the queue at the
//   next edge and drops same-cycle writes.
//   Optional macro INSTQ_PERF_COUNT_EN: adds a saturating 32-bit counter
//   (fullStallCnt_o) of cycles where decode was stalled with valid packets.
//
//   Ports
//     clk      : clock, rising edge
//     reset_n  : asynchronous active-low reset (pointers and count only)
//     q_if     : decode_inst_queue_if.slave, all handshake/data signals
module decode_inst_queue #(
  parameter int PKT_W = 128,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  decode_inst_queue_if.slave  q_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Entry storage carries no reset: an entry is only ever observed while valid.
  logic [PKT_W-1:0] mem_q [DEPTH];

  logic             stall;
  logic             accept;
  logic             we_a, we_b;
  logic [PKT_W-1:0] wdata_a;
  logic [PTR_W-1:0] tail_plus1;
  logic [PTR_W-1:0] head_plus1;
  logic [1:0]       n_push, n_pop;

  // Derived only from the registered count, so it is stable all cycle.
  assign stall      = (count_q > CNT_W'(DEPTH - 2));
  assign tail_plus1 = tail_q + PTR_W'(1);
  assign head_plus1 = head_q + PTR_W'(1);

  always_comb begin
    accept  = !stall && !q_if.flush_i;
    // Compaction: write port A always takes the oldest valid lane at the tail;
    // port B is used only when both lanes are valid.
    we_a    = accept && (q_if.decValid0_i || q_if.decValid1_i);
    wdata_a = q_if.decValid0_i ? q_if.decPacket0_i : q_if.decPacket1_i;
    we_b    = accept && q_if.decValid0_i && q_if.decValid1_i;
    n_push  = {1'b0, we_a} + {1'b0, we_b};

    n_pop = 2'd0;
    if (q_if.renReady_i && !q_if.flush_i) begin
      if (count_q >= CNT_W'(2)) n_pop = 2'd2;
      else                      n_pop = count_q[1:0];
    end

    head_d  = head_q + PTR_W'(n_pop);
    tail_d  = tail_q + PTR_W'(n_push);
    count_d = count_q + CNT_W'(n_push) - CNT_W'(n_pop);

    if (q_if.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_a) mem_q[tail_q]     <= wdata_a;
    if (we_b) mem_q[tail_plus1] <= q_if.decPacket1_i;
  end

  assign q_if.stallDecode_o = stall;
  assign q_if.renValid0_o   = (count_q != '0);
  assign q_if.renValid1_o   = (count_q >= CNT_W'(2));
  assign q_if.renPacket0_o  = q_if.renValid0_o ? mem_q[head_q]     : '0;
  assign q_if.renPacket1_o  = q_if.renValid1_o ? mem_q[head_plus1] : '0;
  assign q_if.count_o       = count_q;

`ifdef INSTQ_PERF_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Flush deliberately does not clear this counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (q_if.decValid0_i || q_if.decValid1_i) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign q_if.fullStallCnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_decode_inst_queue.sv
module tb_decode_inst_queue;
  localparam int PKT_W = 128;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  decode_inst_queue_if #(.PKT_W(PKT_W), .DEPTH(DEPTH)) q_if ();

  decode_inst_queue #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .q_if    (q_if.slave)
  );

  // Reference model: queue contents in age order, plus stall counter.
  logic [PKT_W-1:0] mq [$];
  logic [31:0]      perf_m;
  int               n_cmp = 0;
  int               n_err = 0;
  int               cyc   = 0;

  task automatic chk_eq(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [PKT_W-1:0] e0, e1;
    int sz;
    sz = mq.size();
    e0 = (sz >= 1) ? mq[0] : '0;
    e1 = (sz >= 2) ? mq[1] : '0;
    chk_eq("count",  PKT_W'(q_if.count_o),       PKT_W'(sz));
    chk_eq("stall",  PKT_W'(q_if.stallDecode_o), PKT_W'(sz > DEPTH - 2));
    chk_eq("valid0", PKT_W'(q_if.renValid0_o),   PKT_W'(sz >= 1));
    chk_eq("valid1", PKT_W'(q_if.renValid1_o),   PKT_W'(sz >= 2));
    chk_eq("pkt0",   q_if.renPacket0_o,          e0);
    chk_eq("pkt1",   q_if.renPacket1_o,          e1);
`ifdef INSTQ_PERF_COUNT_EN
    chk_eq("stallcnt", PKT_W'(q_if.fullStallCnt_o), PKT_W'(perf_m));
`endif
  endtask

  function automatic logic [PKT_W-1:0] rnd_pkt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: apply inputs, advance the model by the queue's rules, check.
  task automatic cycle(input logic v0, input logic [PKT_W-1:0] p0,
                       input logic v1, input logic [PKT_W-1:0] p1,
                       input logic rdy, input logic fl);
    bit stall_m;
    int pops;
    q_if.decValid0_i  = v0;
    q_if.decPacket0_i = p0;
    q_if.decValid1_i  = v1;
    q_if.decPacket1_i = p1;
    q_if.renReady_i   = rdy;
    q_if.flush_i      = fl;
    stall_m = (mq.size() > DEPTH - 2);
    if (stall_m && (v0 || v1) && perf_m != 32'hFFFF_FFFF) perf_m++;
    if (fl) begin
      mq.delete();
    end else begin
      pops = rdy ? ((mq.size() < 2) ? mq.size() : 2) : 0;
      repeat (pops) void'(mq.pop_front());
      if (!stall_m) begin
        if (v0) mq.push_back(p0);
        if (v1) mq.push_back(p1);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d v=%b%b rdy=%b fl=%b stall_in=%b -> cnt=%0d", cyc, v0, v1, rdy, fl, stall_m, q_if.count_o);
    check_outputs();
  endtask

  task automatic idle_inputs();
    q_if.decValid0_i  = 1'b0;
    q_if.decValid1_i  = 1'b0;
    q_if.decPacket0_i = '0;
    q_if.decPacket1_i = '0;
    q_if.renReady_i   = 1'b0;
    q_if.flush_i      = 1'b0;
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    perf_m = '0;
    $display("async reset asserted -> cnt=%0d v0=%b v1=%b", q_if.count_o, q_if.renValid0_o, q_if.renValid1_o);
    check_outputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [PKT_W-1:0] pa, pb, pc, pd, pe, z, w0, w1;
  logic [PKT_W-1:0] mem_obs;

  initial begin
    z = '0;
    idle_inputs();
    perf_m  = '0;
    reset_n = 1'b0;
    #12;
    $display("power-on reset -> cnt=%0d", q_if.count_o);
    check_outputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Two-lane push into empty queue, visible after one edge.
    pa = rnd_pkt(); pb = rnd_pkt();
    cycle(1, pa, 1, pb, 0, 0);
    cycle(0, z, 0, z, 1, 0);

    // Lone lane-1 push compacts behind A; then simultaneous push/pop.
    pa = rnd_pkt(); pc = rnd_pkt(); pd = rnd_pkt(); pe = rnd_pkt();
    cycle(1, pa, 0, z, 0, 0);
    cycle(0, z, 1, pc, 0, 0);
    chk_eq("lone_lane1", q_if.renPacket1_o, pc);
    cycle(1, pd, 1, pe, 1, 0);
    cycle(0, z, 0, z, 1, 0);
    cycle(0, z, 0, z, 1, 0);

    // Fill at two per cycle until stalled, then drain in order.
    for (int i = 0; i < 10; i++) cycle(1, rnd_pkt(), 1, rnd_pkt(), 0, 0);
    chk_eq("full_count", PKT_W'(q_if.count_o), PKT_W'(DEPTH));
    chk_eq("full_stall", PKT_W'(q_if.stallDecode_o), PKT_W'(1));
    for (int i = 0; i < 9; i++) cycle(0, z, 0, z, 1, 0);

    // Flush with 7 entries and two incoming packets.
    for (int i = 0; i < 3; i++) cycle(1, rnd_pkt(), 1, rnd_pkt(), 0, 0);
    cycle(1, rnd_pkt(), 0, z, 0, 0);
    cycle(1, rnd_pkt(), 1, rnd_pkt(), 0, 1);
    chk_eq("flush_count", PKT_W'(q_if.count_o), PKT_W'(0));

    // Stalled-with-valid cycles feed the optional counter; flush leaves it.
    for (int i = 0; i < 8; i++) cycle(1, rnd_pkt(), 1, rnd_pkt(), 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, rnd_pkt(), 1, rnd_pkt(), 0, 0);
    cycle(0, z, 0, z, 0, 1);

    // Reset with 5 queued entries, then pointer wrap from slot 0.
    cycle(1, rnd_pkt(), 1, rnd_pkt(), 0, 0);
    cycle(1, rnd_pkt(), 1, rnd_pkt(), 0, 0);
    cycle(1, rnd_pkt(), 0, z, 0, 0);
    async_reset();
    w0 = rnd_pkt(); w1 = rnd_pkt();
    cycle(1, w0, 1, w1, 0, 0);
    mem_obs = dut.mem_q[0];
    chk_eq("slot0_after_reset", mem_obs, w0);
    for (int i = 0; i < 6; i++) cycle(1, rnd_pkt(), 1, rnd_pkt(), 0, 0);
    cycle(1, rnd_pkt(), 0, z, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, z, 0, z, 1, 0);
    w0 = rnd_pkt(); w1 = rnd_pkt();
    cycle(1, w0, 1, w1, 0, 0);
    mem_obs = dut.mem_q[15];
    chk_eq("wrap_slot15", mem_obs, w0);
    mem_obs = dut.mem_q[0];
    chk_eq("wrap_slot0", mem_obs, w1);
    cycle(0, z, 0, z, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 1), rnd_pkt(), $urandom_range(0, 1), rnd_pkt(),
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 31) == 0));
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/decode_inst_queue.md
DECODE_INST_QUEUE -- requirements
Module: decode_inst_queue

Interface
REQ-001 SHALL have parameter PKT_W, default 128, meaning the width of one opaque decoded-instruction packet.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of entries; must be a power of two and at least 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port flush_i, input, 1 bit: discard all queued and incoming packets.
REQ-006 SHALL have ports decPacket0_i and decPacket1_i, input, PKT_W each: decode lane 0 and lane 1 packets.
REQ-007 SHALL have ports decValid0_i and decValid1_i, input, 1 bit each: the lane packet is valid.
REQ-008 SHALL have port stallDecode_o, output, 1 bit: decode must hold its packets.
REQ-009 SHALL have port renReady_i, input, 1 bit: rename consumes all valid output packets this cycle.
REQ-010 SHALL have ports renPacket0_o and renPacket1_o, output, PKT_W each: the oldest and second-oldest entries.
REQ-011 SHALL have ports renValid0_o and renValid1_o, output, 1 bit each: the corresponding output packet is valid.
REQ-012 SHALL have port count_o, output, log2(DEPTH)+1 bits: current occupancy.

Function
REQ-013 SHALL implement a circular FIFO with a head pointer, a tail pointer (both log2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy counter.
REQ-014 SHALL drive stallDecode_o = (count > DEPTH-2), computed only from the registered count, so it is glitch-free within the cycle.
REQ-015 SHALL, when stallDecode_o=0 and flush_i=0, write each valid lane at the tail in program order (lane 0 before lane 1) and compact the writes: a lone decValid1_i writes to the tail slot.
REQ-016 SHALL ignore decode inputs entirely while stallDecode_o=1.
REQ-017 SHALL drive renValid0_o=(count>=1) and renValid1_o=(count>=2), with the packets read from head and head+1 (mod DEPTH); an invalid output packet SHALL read as all zeros.
REQ-018 SHALL, when renReady_i=1 and flush_i=0, pop min(count,2) entries.
REQ-019 SHALL allow push and pop in the same cycle: next count = count + pushes - pops; stall uses the pre-pop count (conservative).
REQ-020 SHALL have a latency of one cycle: a packet written at edge N is visible on the outputs after edge N when the queue was empty.
REQ-021 SHALL give flush_i priority over push and pop: at the next edge head=tail=count=0, same-cycle writes are dropped, and the outputs are invalid the following cycle.
REQ-022 SHALL never overflow (guaranteed by REQ-014) and never underflow (pops are bounded by count).

Reset
REQ-023 SHALL asynchronously set head, tail and count to 0 on reset_n=0, so renValid0_o=renValid1_o=0, renPacket*_o=0, stallDecode_o=0 and count_o=0.
REQ-024 SHALL leave entry storage un-reset; it is unobservable while invalid per REQ-017.
REQ-025 SHALL, when reset asserts mid-operation, discard all contents immediately; the first write after deassertion lands in slot 0.

Configuration
REQ-026 SHALL honour macro INSTQ_PERF_COUNT_EN. When defined: add output fullStallCnt_o, 32 bits, which increments on every cycle with stallDecode_o=1 and decValid0_i|decValid1_i=1, saturates at 0xFFFFFFFF, resets to 0 and is not cleared by flush_i. When undefined: the port and counter are absent and all other behaviour is identical.

Verification
REQ-027 Reset with 5 entries queued -> count_o=0 and both valids=0 immediately, without waiting for a clock edge.
REQ-028 Empty queue, push A (lane 0) and B (lane 1), renReady_i=0 -> the next cycle shows renPacket0_o=A, renPacket1_o=B, count_o=2.
REQ-029 Push 2 per cycle with renReady_i=0 from empty, DEPTH=16 -> stallDecode_o rises when count_o=16 and count stays 16; the packets are then drained in order.
REQ-030 Lone decValid1_i=C into queue {A} -> renPacket1_o=C; then renReady_i=1 with push D,E -> count goes 2 -> 2, and D,E follow C in order.
REQ-031 Tail at slot 15 with 2 pushes -> the entries land in slots 15 and 0, and are read out in order across the wrap.
REQ-032 flush_i=1 with 7 entries plus 2 valid pushes -> the next cycle count_o=0 and valids=0; with INSTQ_PERF_COUNT_EN, 3 stalled-valid cycles give fullStallCnt_o=3.
